fp_mul_pipe: RTL and testbench



---
 rtl/fp_mul_pkg.sv | 56 +++++
 rtl/fp_mul_mant_core.sv | 32 +++
 rtl/fp_mul_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants, class codes and special-value builders for the approximate FP multiplier.
package fp_mul_pkg;

  localparam int unsigned DEF_EXP_WIDTH = 8;
  localparam int unsigned DEF_MAN_WIDTH = 23;
  localparam int unsigned DEF_BIAS      = (1 << (DEF_EXP_WIDTH - 1)) - 1;
  localparam int unsigned MAX_W         = 64;

  localparam logic [1:0] ACC_EXACT   = 2'd0;
  localparam logic [1:0] ACC_HALF    = 2'd1;
  localparam logic [1:0] ACC_QUARTER = 2'd2;
  localparam logic [1:0] ACC_EIGHTH  = 2'd3;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef enum logic [1:0] {SpNone, SpZero, SpInf, SpNan} special_e;

  function automatic fp_class_e classify(logic exp_ones, logic exp_zero, logic man_nz);
    fp_class_e c;
    if (exp_ones) begin
      if (man_nz) c = NAN;
      else        c = INF;
    end else if (exp_zero) begin
      c = ZERO;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

  function automatic logic [MAX_W-1:0] qnan_word(int unsigned ew, int unsigned mw);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ew; i++) r[mw+i] = 1'b1;
    r[mw-1] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] inf_word(logic sign, int unsigned ew, int unsigned mw);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ew; i++) r[mw+i] = 1'b1;
    r[ew+mw] = sign;
    return r;
  endfunction

  // Ones over the top T stored-mantissa bits; T = mw for exact mode, else mw >> mode.
  function automatic logic [MAX_W-1:0] trunc_mask(logic [1:0] mode, int unsigned mw);
    logic [MAX_W-1:0] r;
    int unsigned keep;
    keep = (mode == ACC_EXACT) ? mw : (mw >> mode);
    for (int unsigned i = 0; i < MAX_W; i++) r[i] = (i < mw) && (i >= mw - keep);
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_mant_core.sv
// Stage-2 mantissa multiplier: applies the accuracy truncation mask, registers the exact product.
module fp_mul_mant_core
  import fp_mul_pkg::*;
#(
  parameter int unsigned MAN_WIDTH = DEF_MAN_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   en,
  input  logic [MAN_WIDTH-1:0]   man_x,
  input  logic [MAN_WIDTH-1:0]   man_y,
  input  logic [1:0]             mode,
  output logic [2*MAN_WIDTH+1:0] prod
);

  localparam int unsigned PW = 2 * (MAN_WIDTH + 1);

  logic [MAN_WIDTH-1:0] mask;
  logic [MAN_WIDTH:0]   op_x, op_y;

  always_comb begin
    mask = MAN_WIDTH'(trunc_mask(mode, MAN_WIDTH));
    op_x = {1'b1, man_x & mask};
    op_y = {1'b1, man_y & mask};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)  prod <= '0;
    else if (en) prod <= PW'(op_x) * PW'(op_y);
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage approximate FP multiplier with valid/ready stall.
// Optional Status output enabled by FP_MUL_STATUS_EN.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int unsigned MAN_WIDTH = DEF_MAN_WIDTH
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           In_Valid,
  output logic                           In_Ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   X_Input,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   Y_Input,
  input  logic [1:0]                     Acc_Mode,
  output logic                           Out_Valid,
  input  logic                           Out_Ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   Result
`ifdef FP_MUL_STATUS_EN
  ,
  output logic [3:0]                     Status
`endif
);

  localparam int unsigned W  = EXP_WIDTH + MAN_WIDTH + 1;
  localparam int unsigned PW = 2 * (MAN_WIDTH + 1);
  localparam logic signed [EXP_WIDTH+1:0] BIAS_S  = {3'b000, {(EXP_WIDTH-1){1'b1}}};
  localparam logic signed [EXP_WIDTH+1:0] EXP_MAX = {2'b00, {EXP_WIDTH{1'b1}}};

  logic adv;
  logic out_valid_q;
  logic [W-1:0] result_q;

  assign adv       = ~out_valid_q | Out_Ready;
  assign In_Ready  = adv;
  assign Out_Valid = out_valid_q;
  assign Result    = result_q;

  // S1: unpack, classify, exponent sum
  logic                   sx, sy;
  logic [EXP_WIDTH-1:0]   ex, ey;
  logic [MAN_WIDTH-1:0]   mx, my;
  fp_class_e              cx, cy;
  special_e               kind_d;
  logic signed [EXP_WIDTH+1:0] exp_d;

  assign {sx, ex, mx} = X_Input;
  assign {sy, ey, my} = Y_Input;

  always_comb begin
    cx    = classify(&ex, ~|ex, |mx);
    cy    = classify(&ey, ~|ey, |my);
    exp_d = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_S;
    if (cx == NAN || cy == NAN)                                 kind_d = SpNan;
    else if ((cx == INF && cy == ZERO) || (cx == ZERO && cy == INF)) kind_d = SpNan;
    else if (cx == INF || cy == INF)                            kind_d = SpInf;
    else if (cx == ZERO || cy == ZERO)                          kind_d = SpZero;
    else                                                        kind_d = SpNone;
  end

  logic                        v1_q, s1_sign_q;
  special_e                    s1_kind_q;
  logic signed [EXP_WIDTH+1:0] s1_exp_q;
  logic [MAN_WIDTH-1:0]        s1_mx_q, s1_my_q;
  logic [1:0]                  s1_mode_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_kind_q <= SpNone;
      s1_exp_q  <= '0;
      s1_mx_q   <= '0;
      s1_my_q   <= '0;
      s1_mode_q <= ACC_EXACT;
    end else if (adv) begin
      v1_q      <= In_Valid;
      s1_sign_q <= sx ^ sy;
      s1_kind_q <= kind_d;
      s1_exp_q  <= exp_d;
      s1_mx_q   <= mx;
      s1_my_q   <= my;
      s1_mode_q <= Acc_Mode;
    end
  end

  // S2: mantissa product plus side-band
  logic [PW-1:0]               prod;
  logic                        v2_q, s2_sign_q;
  special_e                    s2_kind_q;
  logic signed [EXP_WIDTH+1:0] s2_exp_q;

  fp_mul_mant_core #(
    .MAN_WIDTH(MAN_WIDTH)
  ) u_mant_core (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .en    (adv),
    .man_x (s1_mx_q),
    .man_y (s1_my_q),
    .mode  (s1_mode_q),
    .prod  (prod)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_kind_q <= SpNone;
      s2_exp_q  <= '0;
    end else if (adv) begin
      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_kind_q <= s1_kind_q;
      s2_exp_q  <= s1_exp_q;
    end
  end

  // S3: normalise (product in [1,4)), truncate, range check, pack
  logic                        norm_hi;
  logic [MAN_WIDTH-1:0]        frac;
  logic signed [EXP_WIDTH+1:0] exp_fin;
  logic [W-1:0]                res_d;
  logic                        ovf_d, unf_d;
  logic                        unused_prod;

  always_comb begin
    norm_hi     = prod[PW-1];
    frac        = norm_hi ? prod[PW-2 -: MAN_WIDTH] : prod[PW-3 -: MAN_WIDTH];
    exp_fin     = s2_exp_q + $signed({{(EXP_WIDTH+1){1'b0}}, norm_hi});
    unused_prod = ^prod[MAN_WIDTH-1:0];
    res_d       = {s2_sign_q, {(W-1){1'b0}}};
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    case (s2_kind_q)
      SpNan:  res_d = W'(qnan_word(EXP_WIDTH, MAN_WIDTH));
      SpInf:  res_d = W'(inf_word(s2_sign_q, EXP_WIDTH, MAN_WIDTH));
      SpZero: res_d = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_fin >= EXP_MAX) begin
          res_d = W'(inf_word(s2_sign_q, EXP_WIDTH, MAN_WIDTH));
          ovf_d = 1'b1;
        end else if (exp_fin[EXP_WIDTH+1] || exp_fin == '0) begin
          unf_d = 1'b1;
        end else begin
          res_d = {s2_sign_q, exp_fin[EXP_WIDTH-1:0], frac};
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (adv) begin
      out_valid_q <= v2_q;
      result_q    <= res_d;
    end
  end

`ifdef FP_MUL_STATUS_EN
  // Approx flag: a nonzero mantissa bit fell outside the kept field.
  logic [MAN_WIDTH-1:0] keep_mask;
  logic                 approx_d, s1_approx_q, s2_approx_q;
  logic [3:0]           status_q;

  always_comb begin
    keep_mask = MAN_WIDTH'(trunc_mask(Acc_Mode, MAN_WIDTH));
    approx_d  = (Acc_Mode != ACC_EXACT) && ((|(mx & ~keep_mask)) || (|(my & ~keep_mask)));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_approx_q <= 1'b0;
      s2_approx_q <= 1'b0;
      status_q    <= '0;
    end else if (adv) begin
      s1_approx_q <= approx_d;
      s2_approx_q <= s1_approx_q;
      status_q    <= {s2_kind_q == SpNan, ovf_d, unf_d, s2_approx_q};
    end
  end

  assign Status = status_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_d ^ unf_d;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe: exact/approx products, specials, stall, reset.
module tb_fp_mul_pipe;

  localparam int unsigned W = 32;
  localparam int NV = 19;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         In_Valid = 1'b0;
  logic         In_Ready;
  logic [W-1:0] X_Input = '0;
  logic [W-1:0] Y_Input = '0;
  logic [1:0]   Acc_Mode = 2'd0;
  logic         Out_Valid;
  logic         Out_Ready = 1'b1;
  logic [W-1:0] Result;
`ifdef FP_MUL_STATUS_EN
  logic [3:0]   Status;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] xv [NV];
  logic [W-1:0] yv [NV];
  logic [W-1:0] ev [NV];
  logic [1:0]   mv [NV];

  fp_mul_pipe #(
    .EXP_WIDTH(8),
    .MAN_WIDTH(23)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .X_Input   (X_Input),
    .Y_Input   (Y_Input),
    .Acc_Mode  (Acc_Mode),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result)
`ifdef FP_MUL_STATUS_EN
    ,
    .Status    (Status)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input int idx, input bit valid);
    In_Valid = valid;
    if (valid) begin
      X_Input  = xv[idx];
      Y_Input  = yv[idx];
      Acc_Mode = mv[idx];
    end else begin
      X_Input  = '0;
      Y_Input  = '0;
      Acc_Mode = 2'd0;
    end
  endtask

  // Streams vectors base..base+n-1; Out_Ready low for cycles [stall_at, stall_at+stall_len).
  task automatic run_stream(input int base, input int n, input int stall_at, input int stall_len);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    bit acc;
    bit hold = 0;
    bit extra = 0;
    logic [W-1:0] held = '0;
    @(posedge Clk);
    #1;
    Out_Ready = 1'b1;
    set_inputs(base, 1'b1);
    while (out_idx < n && cyc < 200) begin
      @(negedge Clk);
      if (hold) begin
        check("hold_result", Result, held);
        check("hold_valid", Out_Valid, 1'b1);
      end
      if (Out_Valid && !Out_Ready) check("stall_in_ready", In_Ready, 1'b0);
      if (Out_Valid && Out_Ready) begin
        check($sformatf("res[%0d]", base + out_idx), Result, ev[base + out_idx]);
        out_idx++;
      end
      acc  = In_Valid && In_Ready;
      hold = Out_Valid && !Out_Ready;
      held = Result;
      @(posedge Clk);
      #1;
      if (acc) in_idx++;
      cyc++;
      Out_Ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      set_inputs(base + in_idx, in_idx < n);
    end
    check("stream_count", out_idx, n);
    set_inputs(0, 1'b0);
    Out_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Out_Valid) extra = 1;
    end
    check("no_extra_output", extra, 1'b0);
  endtask

  initial begin
    int lat;
    bit stale;
    xv = '{32'h3FC00000, 32'hBF800000, 32'h3FF00000, 32'h3FF00000, 32'h3FFFFFFF,
           32'h3FFFFFFF, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h7F000000, 32'h00800000,
           32'h00000001, 32'h7F800000, 32'hFFC12345, 32'hFF800000, 32'h3FC00000,
           32'h80000000, 32'h80800000, 32'h7F000000, 32'h3FFFFFFF};
    yv = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000,
           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000,
           32'h3F800000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h3FC00000,
           32'h3F800000, 32'h3F000000, 32'h3FFFFFFF, 32'h3FFFFFFF};
    mv = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0,
           2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ev = '{32'h40400000, 32'hBF800000, 32'h40700000, 32'h40600000, 32'h3FFFFFFF,
           32'h3FFFF000, 32'h3FFC0000, 32'h3FE00000, 32'h7F800000, 32'h00000000,
           32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h40100000,
           32'h80000000, 32'h80000000, 32'h7F7FFFFF, 32'h407FFFFE};

    #12;
    check("reset_out_valid", Out_Valid, 1'b0);
    check("reset_result", Result, '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check("ready_after_reset", In_Ready, 1'b1);

    // Single op: latency from accept to Out_Valid
    set_inputs(0, 1'b1);
    @(negedge Clk);
    check("single_accept", In_Ready, 1'b1);
    @(posedge Clk);
    #1;
    set_inputs(0, 1'b0);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Out_Valid) break;
      lat++;
    end
    check("latency", lat, 3);
    check("single_result", Result, ev[0]);

    run_stream(0, NV, 0, 0);
    run_stream(0, 8, 3, 5);

    // Reset with operations in flight
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(i, 1'b1);
      @(posedge Clk);
      #1;
    end
    set_inputs(0, 1'b0);
    check("pre_reset_valid", Out_Valid, 1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset_valid", Out_Valid, 1'b0);
    check("async_reset_result", Result, '0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Out_Valid || Result != '0) stale = 1;
    end
    check("no_stale_after_reset", stale, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
